// File: rtl/decoder3_8_pipe.sv
// decoder3_8_pipe: registered binary-to-one-hot decoder behind a valid/ready
// handshake, with a 2-entry output FIFO so a full word per cycle is sustained
// under backpressure.
// Optional feature macro: DEC_COUNT_EN. When it is defined, dec_cnt is a
// saturating count of accepted words. When it is undefined, dec_cnt is tied to 0.
module decoder3_8_pipe #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 1 << IN_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_y,
    output logic             out_err,
    output logic [CNT_W-1:0] dec_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [OUT_W-1:0]   head_y_r;
    logic [OUT_W-1:0]   tail_y_r;
    logic               head_err_r;
    logic               tail_err_r;
    logic [OUT_W-1:0]   next_head_y_s;
    logic [OUT_W-1:0]   next_tail_y_s;
    logic               next_head_err_s;
    logic               next_tail_err_s;
    logic [OUT_W-1:0]   new_y_s;
    logic               new_err_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               push_s;
    logic               pop_s;

    // Returns {err, y}. A disabled decoder gives all zeros. An out-of-range
    // code flags err and leaves y at zero, so y is never multi-hot.
    function automatic logic [OUT_W:0] decode_entry(input logic [IN_W-1:0] code,
                                                    input logic            en);
        logic [OUT_W-1:0] y;
        logic             err;
        int               code_i;
        y      = {OUT_W{1'b0}};
        err    = 1'b0;
        code_i = int'(code);
        if (en) begin
            if (code_i < OUT_W) begin
                for (int i = 0; i < OUT_W; i++) begin
                    y[i] = (code_i == i);
                end
            end else begin
                err = 1'b1;
            end
        end else begin
            err = 1'b0;
        end
        return {err, y};
    endfunction

    assign push_s               = in_valid & in_ready_r;
    assign pop_s                = out_valid_r & out_ready;
    assign {new_err_s, new_y_s} = decode_entry(in_code, in_en);

    // Occupancy next-state plus head/tail update. A slot that goes empty is
    // cleared so that out_y and out_err read zero while nothing is valid.
    always_comb begin
        next_state_s    = state_r;
        next_head_y_s   = head_y_r;
        next_head_err_s = head_err_r;
        next_tail_y_s   = tail_y_r;
        next_tail_err_s = tail_err_r;
        case (state_r)
            ST_EMPTY: begin
                if (push_s) begin
                    next_state_s    = ST_ONE;
                    next_head_y_s   = new_y_s;
                    next_head_err_s = new_err_s;
                end else begin
                    next_state_s    = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (push_s && pop_s) begin
                    next_head_y_s   = new_y_s;
                    next_head_err_s = new_err_s;
                end else if (push_s) begin
                    next_state_s    = ST_FULL;
                    next_tail_y_s   = new_y_s;
                    next_tail_err_s = new_err_s;
                end else if (pop_s) begin
                    next_state_s    = ST_EMPTY;
                    next_head_y_s   = {OUT_W{1'b0}};
                    next_head_err_s = 1'b0;
                end else begin
                    next_state_s    = ST_ONE;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    next_state_s    = ST_ONE;
                    next_head_y_s   = tail_y_r;
                    next_head_err_s = tail_err_r;
                    next_tail_y_s   = {OUT_W{1'b0}};
                    next_tail_err_s = 1'b0;
                end else begin
                    next_state_s    = ST_FULL;
                end
            end
            default: begin
                next_state_s    = ST_EMPTY;
                next_head_y_s   = {OUT_W{1'b0}};
                next_head_err_s = 1'b0;
                next_tail_y_s   = {OUT_W{1'b0}};
                next_tail_err_s = 1'b0;
            end
        endcase
    end

    // State, FIFO storage and the handshake flags. The flags are registered
    // decodes of the next state, so in_ready has no path from out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            head_y_r    <= {OUT_W{1'b0}};
            head_err_r  <= 1'b0;
            tail_y_r    <= {OUT_W{1'b0}};
            tail_err_r  <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            head_y_r    <= next_head_y_s;
            head_err_r  <= next_head_err_s;
            tail_y_r    <= next_tail_y_s;
            tail_err_r  <= next_tail_err_s;
            in_ready_r  <= (next_state_s != ST_FULL);
            out_valid_r <= (next_state_s != ST_EMPTY);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_y     = head_y_r;
    assign out_err   = head_err_r;

`ifdef DEC_COUNT_EN
    logic [CNT_W-1:0] cnt_r;

    // Count every accepted word. The count sticks at all-ones and is cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (push_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign dec_cnt = cnt_r;
`else
    assign dec_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_decoder3_8_pipe.sv
// Scoreboard bench for decoder3_8_pipe. It drives two instances from the same
// stimulus: a full 8-output decoder, and a 6-output decoder whose codes 6 and 7
// are out of range. The stimulus is a set of directed vectors. Each vector
// carries its hand-computed expected {err, y} for both instances.
module tb_decoder3_8_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_en;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_err_a;
    logic [7:0] out_y_a, dec_cnt_a;
    logic       in_ready_b, out_valid_b, out_err_b;
    logic [5:0] out_y_b;
    logic [3:0] dec_cnt_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_n = 0;

    logic [8:0] q_a[$];
    logic [6:0] q_b[$];
    logic [8:0] exp_a, hold_a;
    logic [6:0] exp_b, hold_b;
    logic       hold_a_v = 1'b0;
    logic       hold_b_v = 1'b0;

    // Hand-computed expectations for codes 0..7 with en=1.
    logic [8:0] ea_tab [8] = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020, 9'h040, 9'h080};
    logic [6:0] eb_tab [8] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h40};

    decoder3_8_pipe #(.IN_W(3), .OUT_W(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_code(in_code), .in_en(in_en), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_y(out_y_a), .out_err(out_err_a), .dec_cnt(dec_cnt_a)
    );

    decoder3_8_pipe #(.IN_W(3), .OUT_W(6), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_code(in_code), .in_en(in_en), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_y(out_y_b), .out_err(out_err_b), .dec_cnt(dec_cnt_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for instance a. It pops and compares on every output transfer, and
    // it checks that the head holds while it is stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_a && out_ready) begin
                if (q_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_a: got output %0h expected no output", {out_err_a, out_y_a});
                end else begin
                    exp_a = q_a.pop_front();
                    check("out_a", 32'({out_err_a, out_y_a}), 32'(exp_a));
                end
            end
            if (hold_a_v && out_valid_a) check("hold_a", 32'({out_err_a, out_y_a}), 32'(hold_a));
            hold_a_v = out_valid_a && !out_ready;
            hold_a   = {out_err_a, out_y_a};
        end else begin
            hold_a_v = 1'b0;
        end
    end

    // Monitor for instance b, which is the same as the monitor for instance a.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_b && out_ready) begin
                if (q_b.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_b: got output %0h expected no output", {out_err_b, out_y_b});
                end else begin
                    exp_b = q_b.pop_front();
                    check("out_b", 32'({out_err_b, out_y_b}), 32'(exp_b));
                end
            end
            if (hold_b_v && out_valid_b) check("hold_b", 32'({out_err_b, out_y_b}), 32'(hold_b));
            hold_b_v = out_valid_b && !out_ready;
            hold_b   = {out_err_b, out_y_b};
        end else begin
            hold_b_v = 1'b0;
        end
    end

    // Present one word and hold it until it is accepted. The expectation is
    // pushed at the accept.
    task automatic send(input logic [2:0] c, input logic e, input logic [8:0] ea, input logic [6:0] eb);
        logic acc = 1'b0;
        int   n   = 0;
        in_valid = 1'b1;
        in_code  = c;
        in_en    = e;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready_a;
            if (in_ready_a) q_a.push_back(ea);
            if (in_ready_b) q_b.push_back(eb);
            if (in_ready_a) acc_n++;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 32'(q_a.size() + q_b.size()), 32'd0);
    endtask

    task automatic check_cnt(input string tag);
`ifdef DEC_COUNT_EN
        check({tag, "_cnt_a"}, 32'(dec_cnt_a), 32'((acc_n > 255) ? 255 : acc_n));
        check({tag, "_cnt_b"}, 32'(dec_cnt_b), 32'((acc_n > 15) ? 15 : acc_n));
`else
        check({tag, "_cnt_a"}, 32'(dec_cnt_a), 32'd0);
        check({tag, "_cnt_b"}, 32'(dec_cnt_b), 32'd0);
`endif
    endtask

    initial begin
        int c0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = 3'd0;
        in_en     = 1'b0;
        out_ready = 1'b1;
        #1;
        // Reset state
        check("rst_in_ready", 32'({in_ready_a, in_ready_b}), 32'd3);
        check("rst_out_valid", 32'({out_valid_a, out_valid_b}), 32'd0);
        check("rst_out_y", 32'({out_y_a, out_y_b}), 32'd0);
        check("rst_out_err", 32'({out_err_a, out_err_b}), 32'd0);
        check_cnt("rst");
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Codes 0..7 streamed with one-cycle latency and one word per cycle
        c0 = cyc;
        send(3'd0, 1'b1, ea_tab[0], eb_tab[0]);
        check("latency_valid", 32'(out_valid_a), 32'd1);
        check("latency_y", 32'(out_y_a), 32'h01);
        for (int i = 1; i < 8; i++) send(3'(i), 1'b1, ea_tab[i], eb_tab[i]);
        check("throughput", 32'(cyc - c0), 32'd8);
        drain();
        check_cnt("stream");

        // Disabled decoder and out-of-range codes
        send(3'd5, 1'b0, 9'h000, 7'h00);
        send(3'd7, 1'b1, 9'h080, 7'h40);
        send(3'd6, 1'b1, 9'h040, 7'h40);
        send(3'd0, 1'b0, 9'h000, 7'h00);
        drain();

        // Backpressure: the FIFO fills after two accepts and code 3 waits
        out_ready = 1'b0;
        send(3'd1, 1'b1, 9'h002, 7'h02);
        send(3'd2, 1'b1, 9'h004, 7'h04);
        check("full_in_ready", 32'({in_ready_a, in_ready_b}), 32'd0);
        check("full_head", 32'(out_y_a), 32'h02);
        fork
            send(3'd3, 1'b1, 9'h008, 7'h08);
            begin
                repeat (3) @(posedge clk);
                #2;
                check("stall_in_ready", 32'(in_ready_a), 32'd0);
                check("stall_head", 32'({out_err_a, out_y_a}), 32'h002);
                out_ready = 1'b1;
            end
        join
        drain();
        check_cnt("bp");

        // Simultaneous push and pop while one word is held
        for (int i = 0; i < 11; i++) begin
            send(3'(i % 8), 1'b1, ea_tab[i % 8], eb_tab[i % 8]);
            check("one_ready", 32'(in_ready_a), 32'd1);
            check("one_valid", 32'(out_valid_a), 32'd1);
        end
        drain();
        check_cnt("pushpop");
        send(3'd4, 1'b0, 9'h000, 7'h00);
        send(3'd2, 1'b1, 9'h004, 7'h04);
        drain();
        check_cnt("sat");

        // Asynchronous reset mid-cycle while the FIFO is full
        out_ready = 1'b0;
        send(3'd6, 1'b1, 9'h040, 7'h40);
        send(3'd7, 1'b1, 9'h080, 7'h40);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'({out_valid_a, out_valid_b}), 32'd0);
        check("arst_in_ready", 32'({in_ready_a, in_ready_b}), 32'd3);
        check("arst_out_y", 32'({out_err_a, out_y_a, out_err_b, out_y_b}), 32'd0);
        q_a.delete();
        q_b.delete();
        acc_n = 0;
        check_cnt("arst");
        @(negedge clk);
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(3'd3, 1'b1, 9'h008, 7'h08);
        drain();
        check_cnt("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
